// File: rtl/spi_ram_reader.sv
// SPI byte-read front end over a 16-bit SDRAM port: current/next word buffers,
// one-word prefetch and a low-priority host word-write path.
module spi_ram_reader #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int PREFETCH   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           spi_read_addr,
    input  logic                  spi_read_strobe,
    output logic [7:0]            spi_read_data,
    output logic                  spi_read_ready,
    input  logic                  spi_critical,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic                  host_wr_strobe,
    output logic                  host_wr_ready,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [DATA_WIDTH-1:0] sd_wr_data,
    output logic                  sd_we,
    output logic                  sd_enable,
    input  logic                  sd_ack,
    input  logic [DATA_WIDTH-1:0] sd_rd_data,
    output logic                  sd_refresh_inhibit
);

    typedef enum logic [1:0] {IDLE, DEMAND, PREF, WRITE} state_t;

    state_t                state, state_n;
    logic                  cur_valid, cur_valid_n, nxt_valid, nxt_valid_n;
    logic [ADDR_WIDTH-1:0] cur_tag, cur_tag_n, nxt_tag, nxt_tag_n;
    logic [DATA_WIDTH-1:0] cur_data, cur_data_n, nxt_data, nxt_data_n;
    logic                  pend_valid, pend_valid_n, pend_byte, pend_byte_n;
    logic [ADDR_WIDTH-1:0] pend_word, pend_word_n;
    logic                  svc_byte, svc_byte_n;
    logic [ADDR_WIDTH-1:0] sd_addr_n;
    logic [DATA_WIDTH-1:0] sd_wr_data_n;
    logic                  sd_we_n, sd_enable_n;
    logic                  ready_n;
    logic [7:0]            rdata_n;
    logic                  idle_q, idle_n;

    logic [ADDR_WIDTH-1:0] strobe_word, req_word;
    logic                  req_valid, req_byte, do_eval, host_accept;
    logic                  unused_addr_bits;

    assign strobe_word      = spi_read_addr[ADDR_WIDTH:1];
    assign unused_addr_bits = ^spi_read_addr[31:ADDR_WIDTH+1];

    // SPI strobes win over a host strobe arriving in the same cycle.
    assign host_wr_ready = idle_q && !spi_critical && !spi_read_strobe;
    assign host_accept   = host_wr_strobe && host_wr_ready;

    function automatic logic [7:0] sel_byte(input logic [DATA_WIDTH-1:0] w, input logic b);
        return b ? w[15:8] : w[7:0];
    endfunction

    always_comb begin
        state_n      = state;
        cur_valid_n  = cur_valid;
        cur_tag_n    = cur_tag;
        cur_data_n   = cur_data;
        nxt_valid_n  = nxt_valid;
        nxt_tag_n    = nxt_tag;
        nxt_data_n   = nxt_data;
        pend_valid_n = pend_valid;
        pend_word_n  = pend_word;
        pend_byte_n  = pend_byte;
        svc_byte_n   = svc_byte;
        sd_addr_n    = sd_addr;
        sd_wr_data_n = sd_wr_data;
        sd_we_n      = sd_we;
        sd_enable_n  = sd_enable;
        ready_n      = 1'b0;
        rdata_n      = spi_read_data;
        do_eval      = 1'b0;

        req_valid = spi_read_strobe || pend_valid;
        req_word  = spi_read_strobe ? strobe_word : pend_word;
        req_byte  = spi_read_strobe ? spi_read_addr[0] : pend_byte;

        if (spi_read_strobe) begin
            pend_valid_n = 1'b1;
            pend_word_n  = strobe_word;
            pend_byte_n  = spi_read_addr[0];
        end

        case (state)
            IDLE: begin
                do_eval = 1'b1;
                if (host_accept) begin
                    state_n      = WRITE;
                    sd_addr_n    = host_wr_addr;
                    sd_wr_data_n = host_wr_data;
                    sd_we_n      = 1'b1;
                    sd_enable_n  = 1'b1;
                    if (cur_tag == host_wr_addr) cur_valid_n = 1'b0;
                    if (nxt_tag == host_wr_addr) nxt_valid_n = 1'b0;
                end
            end
            DEMAND: begin
                if (sd_enable && sd_ack) begin
                    cur_valid_n = 1'b1;
                    cur_tag_n   = sd_addr;
                    cur_data_n  = sd_rd_data;
                    nxt_valid_n = 1'b0;
                    ready_n     = 1'b1;
                    rdata_n     = sel_byte(sd_rd_data, svc_byte);
                    sd_enable_n = 1'b0;
                    if (PREFETCH != 0) begin
                        state_n   = PREF;
                        sd_addr_n = sd_addr + ADDR_WIDTH'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    sd_enable_n = 1'b1;
                end
            end
            PREF: begin
                if (sd_enable && sd_ack) begin
                    nxt_valid_n = 1'b1;
                    nxt_tag_n   = sd_addr;
                    nxt_data_n  = sd_rd_data;
                    sd_enable_n = 1'b0;
                    state_n     = IDLE;
                    do_eval     = 1'b1;
                end else begin
                    sd_enable_n = 1'b1;
                end
            end
            WRITE: begin
                if (sd_enable && sd_ack) begin
                    sd_enable_n = 1'b0;
                    sd_we_n     = 1'b0;
                    state_n     = IDLE;
                end else begin
                    sd_enable_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Evaluated against the *_n buffer view so a request landing on PREF
        // completion can hit the word being written into the next buffer.
        if (do_eval && req_valid) begin
            pend_valid_n = 1'b0;
            if (cur_valid_n && cur_tag_n == req_word) begin
                ready_n = 1'b1;
                rdata_n = sel_byte(cur_data_n, req_byte);
            end else if (nxt_valid_n && nxt_tag_n == req_word) begin
                ready_n     = 1'b1;
                rdata_n     = sel_byte(nxt_data_n, req_byte);
                cur_valid_n = 1'b1;
                cur_tag_n   = nxt_tag_n;
                cur_data_n  = nxt_data_n;
                nxt_valid_n = 1'b0;
                if (PREFETCH != 0) begin
                    state_n     = PREF;
                    sd_addr_n   = req_word + ADDR_WIDTH'(1);
                    sd_we_n     = 1'b0;
                    sd_enable_n = (state == IDLE);
                end
            end else begin
                state_n     = DEMAND;
                sd_addr_n   = req_word;
                sd_we_n     = 1'b0;
                svc_byte_n  = req_byte;
                sd_enable_n = (state == IDLE);
            end
        end

        idle_n = (state_n == IDLE) && !pend_valid_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cur_valid          <= 1'b0;
            cur_tag            <= '0;
            cur_data           <= '0;
            nxt_valid          <= 1'b0;
            nxt_tag            <= '0;
            nxt_data           <= '0;
            pend_valid         <= 1'b0;
            pend_word          <= '0;
            pend_byte          <= 1'b0;
            svc_byte           <= 1'b0;
            sd_addr            <= '0;
            sd_wr_data         <= '0;
            sd_we              <= 1'b0;
            sd_enable          <= 1'b0;
            spi_read_ready     <= 1'b0;
            spi_read_data      <= '0;
            idle_q             <= 1'b0;
            sd_refresh_inhibit <= 1'b0;
        end else begin
            state              <= state_n;
            cur_valid          <= cur_valid_n;
            cur_tag            <= cur_tag_n;
            cur_data           <= cur_data_n;
            nxt_valid          <= nxt_valid_n;
            nxt_tag            <= nxt_tag_n;
            nxt_data           <= nxt_data_n;
            pend_valid         <= pend_valid_n;
            pend_word          <= pend_word_n;
            pend_byte          <= pend_byte_n;
            svc_byte           <= svc_byte_n;
            sd_addr            <= sd_addr_n;
            sd_wr_data         <= sd_wr_data_n;
            sd_we              <= sd_we_n;
            sd_enable          <= sd_enable_n;
            spi_read_ready     <= ready_n;
            spi_read_data      <= rdata_n;
            idle_q             <= idle_n;
            sd_refresh_inhibit <= spi_critical;
        end
    end

endmodule

// File: tb/tb_spi_ram_reader.sv
// Bench for spi_ram_reader: SDRAM behavioural memory, directed scenarios and a
// randomized read/write phase checked against memory contents.
module tb_spi_ram_reader;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   spi_read_addr = '0;
    logic          spi_read_strobe = 1'b0;
    logic [7:0]    spi_read_data;
    logic          spi_read_ready;
    logic          spi_critical = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [15:0]   host_wr_data = '0;
    logic          host_wr_strobe = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] sd_addr;
    logic [15:0]   sd_wr_data;
    logic          sd_we;
    logic          sd_enable;
    logic          sd_ack = 1'b0;
    logic [15:0]   sd_rd_data = '0;
    logic          sd_refresh_inhibit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .PREFETCH(1)) dut (
        .clk(clk), .reset(reset),
        .spi_read_addr(spi_read_addr), .spi_read_strobe(spi_read_strobe),
        .spi_read_data(spi_read_data), .spi_read_ready(spi_read_ready),
        .spi_critical(spi_critical),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_strobe(host_wr_strobe), .host_wr_ready(host_wr_ready),
        .sd_addr(sd_addr), .sd_wr_data(sd_wr_data), .sd_we(sd_we),
        .sd_enable(sd_enable), .sd_ack(sd_ack), .sd_rd_data(sd_rd_data),
        .sd_refresh_inhibit(sd_refresh_inhibit)
    );

    logic [15:0] mem [int unsigned];

    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return 16'((32'(a) * 32'h9E37) ^ 32'h5A5A);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SDRAM side: random (or forced) ack latency, access log.
    int            lat = -1;
    int            force_lat = -1;
    logic [AW-1:0] log_addr[$];
    logic          log_we[$];
    int            log_cyc[$];
    logic          held = 1'b0;
    logic [AW-1:0] held_addr;
    logic          held_we;
    int            en_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            sd_ack = 1'b0;
            lat    = -1;
            held   = 1'b0;
        end else if (sd_ack) begin
            sd_ack = 1'b0;
            lat    = -1;
            held   = 1'b0;
            check("enable_drop", 32'(sd_enable), 32'd0);
        end else if (sd_enable) begin
            en_cnt++;
            if (held) begin
                check("addr_stable", 32'(sd_addr), 32'(held_addr));
                check("we_stable", 32'(sd_we), 32'(held_we));
            end else begin
                held      = 1'b1;
                held_addr = sd_addr;
                held_we   = sd_we;
            end
            if (lat < 0) lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            if (lat == 0) begin
                sd_ack = 1'b1;
                log_addr.push_back(sd_addr);
                log_we.push_back(sd_we);
                log_cyc.push_back(cyc);
                if (sd_we) mem[32'(sd_addr)] = sd_wr_data;
                else sd_rd_data = mem_rd(sd_addr);
            end else begin
                lat--;
            end
        end
    end

    int         ready_cnt = 0;
    int         ready_cyc = 0;
    logic [7:0] ready_data = '0;

    always @(negedge clk) begin
        if (spi_read_ready) begin
            ready_cnt++;
            ready_cyc  = cyc;
            ready_data = spi_read_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!host_wr_ready && n < 300) begin tick(); n++; end
        check("idle_timeout", 32'(host_wr_ready), 32'd1);
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!sd_enable && n < 300) begin tick(); n++; end
        check("enable_timeout", 32'(sd_enable), 32'd1);
    endtask

    task automatic wait_ready(input int base);
        int n = 0;
        while (ready_cnt == base && n < 300) begin tick(); n++; end
        check("ready_timeout", 32'(ready_cnt > base), 32'd1);
    endtask

    task automatic spi_strobe(input logic [31:0] a);
        spi_read_addr   = a;
        spi_read_strobe = 1'b1;
        tick();
        spi_read_strobe = 1'b0;
    endtask

    // exp_lat < 0: latency not checked.
    task automatic spi_read(input logic [31:0] a, input string tag, input int exp_lat);
        int            base = ready_cnt;
        int            s = cyc;
        logic [AW-1:0] w = a[AW:1];
        logic [15:0]   word = mem_rd(w);
        logic [7:0]    e = a[0] ? word[15:8] : word[7:0];
        spi_strobe(a);
        wait_ready(base);
        check({tag, "_data"}, 32'(ready_data), 32'(e));
        if (exp_lat > 0) check({tag, "_lat"}, 32'(ready_cyc - s), 32'(exp_lat));
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
        wait_idle();
        host_wr_addr   = a;
        host_wr_data   = d;
        host_wr_strobe = 1'b1;
        tick();
        host_wr_strobe = 1'b0;
        wait_idle();
        check("host_write", 32'(mem_rd(a)), 32'(d));
    endtask

    initial begin
        int            base, base_log, e0, n12, nwe;
        logic [AW-1:0] w, cw;
        logic [15:0]   d, tmp;
        logic [7:0]    eb;
        bit            cv, idle, b;

        mem[32'h11] = 16'h1234;
        repeat (3) tick();
        check("rst_ready", 32'(spi_read_ready), 32'd0);
        check("rst_enable", 32'(sd_enable), 32'd0);
        check("rst_we", 32'(sd_we), 32'd0);
        check("rst_wr_ready", 32'(host_wr_ready), 32'd0);
        check("rst_inhibit", 32'(sd_refresh_inhibit), 32'd0);
        check("rst_data", 32'(spi_read_data), 32'd0);
        reset = 1'b0;
        tick();

        // Miss after host write, then current-buffer hit on the other byte.
        host_write(24'h10, 16'hBEEF);
        base_log = log_addr.size();
        base = ready_cnt;
        spi_strobe(32'h20);
        wait_ready(base);
        check("miss_data", 32'(ready_data), 32'hEF);
        check("miss_addr", 32'(log_addr[base_log]), 32'h10);
        check("miss_lat", 32'(ready_cyc - log_cyc[base_log]), 32'd1);
        wait_idle();
        e0 = en_cnt;
        spi_read(32'h21, "cur_hit", 1);
        check("cur_hit_noen", 32'(en_cnt), 32'(e0));

        // Next-buffer hit (word 0x11 prefetched), launches PREF of 0x12.
        spi_read(32'h20, "cur_hit2", 1);
        force_lat = 6;
        spi_read(32'h22, "nxt_hit", 1);
        check("nxt_hit_val", 32'(ready_data), 32'h34);
        wait_enable();
        check("pref_addr", 32'(sd_addr), 32'h12);
        check("pref_we", 32'(sd_we), 32'd0);

        // Strobe during PREF: served from the freshly prefetched word.
        base_log = log_addr.size();
        spi_read(32'h25, "pref_strobe", -1);
        n12 = 0;
        for (int k = base_log; k < log_addr.size(); k++) if (log_addr[k] == 24'h12) n12++;
        check("pref_single", 32'(n12), 32'd1);

        // Two strobes during PREF: only the latest is answered.
        wait_enable();
        check("pref2_addr", 32'(sd_addr), 32'h13);
        base = ready_cnt;
        spi_strobe(32'h30);
        spi_strobe(32'h27);
        wait_idle();
        tmp = mem_rd(24'h13);
        check("two_strobe_cnt", 32'(ready_cnt - base), 32'd1);
        check("two_strobe_data", 32'(ready_data), 32'(tmp[15:8]));
        force_lat = -1;

        // Word-address wrap on prefetch.
        base_log = log_addr.size();
        spi_read(32'h1FFFFFE, "wrap", -1);
        wait_idle();
        check("wrap_dem", 32'(log_addr[base_log]), 32'hFFFFFF);
        check("wrap_pref", 32'(log_addr[base_log + 1]), 32'h0);

        // Refresh inhibit and host gating by spi_critical.
        spi_critical = 1'b1;
        #1;
        check("inhibit_delay", 32'(sd_refresh_inhibit), 32'd0);
        check("crit_wr_ready", 32'(host_wr_ready), 32'd0);
        tick();
        check("inhibit_on", 32'(sd_refresh_inhibit), 32'd1);
        spi_critical = 1'b0;
        tick();
        check("inhibit_off", 32'(sd_refresh_inhibit), 32'd0);
        check("wr_ready_back", 32'(host_wr_ready), 32'd1);

        // Simultaneous host and SPI strobes: SPI wins, no write issued.
        base_log = log_addr.size();
        base = ready_cnt;
        tmp = mem_rd(24'h40);
        eb = tmp[7:0];
        host_wr_addr = 24'h40;
        host_wr_data = 16'h5555;
        host_wr_strobe = 1'b1;
        spi_read_addr = 32'h80;
        spi_read_strobe = 1'b1;
        #1;
        check("collide_wr_ready", 32'(host_wr_ready), 32'd0);
        tick();
        host_wr_strobe = 1'b0;
        spi_read_strobe = 1'b0;
        wait_ready(base);
        wait_idle();
        check("collide_data", 32'(ready_data), 32'(eb));
        nwe = 0;
        for (int k = base_log; k < log_we.size(); k++) if (log_we[k]) nwe++;
        check("collide_no_write", 32'(nwe), 32'd0);

        // Host write to the current word forces a re-read.
        spi_read(32'hA0, "pre_wr", -1);
        host_write(24'h50, 16'hCAFE);
        base_log = log_addr.size();
        spi_read(32'hA1, "after_wr", -1);
        check("after_wr_val", 32'(ready_data), 32'hCA);
        check("after_wr_reread", 32'(log_addr[base_log]), 32'h50);

        // Randomized mix over a small window so buffers hit and get invalidated.
        cw = 24'h50;
        cv = 1'b1;
        for (int i = 0; i < 48; i++) begin
            w = 24'h100 + AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                d = 16'($urandom);
                host_write(w, d);
                if (w == cw) cv = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 1) wait_idle();
                idle = host_wr_ready;
                b = 1'($urandom_range(0, 1));
                spi_read({7'b0, w, b}, "rand", (idle && cv && w == cw) ? 1 : -1);
                cw = w;
                cv = 1'b1;
            end
        end

        // Reset during an access: enable drops at once, no ready follows.
        wait_idle();
        force_lat = 8;
        spi_strobe(32'h400);
        wait_enable();
        base = ready_cnt;
        reset = 1'b1;
        #1;
        check("reset_enable", 32'(sd_enable), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        force_lat = -1;
        repeat (12) tick();
        check("reset_no_ready", 32'(ready_cnt), 32'(base));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_ram_reader.md
Name: spi_ram_reader

Overview:
- Memory-side stage directly downstream of spi_flash's read-request interface. Turns SPI byte-address read requests into 16-bit SDRAM word reads through sdram_ctrl's logical port and returns the selected byte.
- Holds a current-word buffer and a one-word prefetch buffer so sequential flash reads are served without waiting on SDRAM.
- Arbitrates a host (UART-side) word-write port used to load the flash image. SPI reads always take priority.

Parameters:
ADDR_WIDTH, 24, SDRAM word-address width.
DATA_WIDTH, 16, SDRAM word width (fixed to 16).
PREFETCH, 1, when 1, fetch word+1 after each demand fetch or next-buffer hit; when 0, no prefetch.

Ports:
clk  in  1  system clock (132 MHz)
reset  in  1  asynchronous, active-high
spi_read_addr  in  32  byte address from spi_flash; bits [ADDR_WIDTH:1] are the word address, bit 0 is the byte select
spi_read_strobe  in  1  one-cycle pulse, address valid
spi_read_data  out  8  returned byte
spi_read_ready  out  1  one-cycle pulse, spi_read_data valid
spi_critical  in  1  timing-critical SPI transaction in progress
host_wr_addr  in  ADDR_WIDTH  word address for a host write
host_wr_data  in  16  write data
host_wr_strobe  in  1  write request; honoured only when host_wr_ready=1
host_wr_ready  out  1  write port can accept
sd_addr  out  ADDR_WIDTH  to sdram_ctrl adr_i
sd_wr_data  out  16  to dat_i
sd_we  out  1  to we_i
sd_enable  out  1  to acc_i
sd_ack  in  1  from ack_raw; read data valid / write done this cycle
sd_rd_data  in  16  from dat_raw
sd_refresh_inhibit  out  1  to refresh_inhibit_i

Behaviour:
- Reset values (asynchronous): all outputs 0; both buffers invalid; state IDLE; no pending request.
- Byte select: addr[0]=0 returns word[7:0]; addr[0]=1 returns word[15:8].
- sd_refresh_inhibit is spi_critical registered by one clk.
- States:
  - IDLE: waiting for a request.
  - DEMAND: reading the requested word.
  - PREF: reading word+1 into the next buffer.
  - WRITE: host write in progress.
- SDRAM handshake:
  - In DEMAND, PREF and WRITE, sd_enable is held at 1 with sd_addr, sd_we and sd_wr_data stable until the cycle sd_ack=1.
  - sd_enable drops to 0 on the cycle after sd_ack.
  - Read data is captured on the sd_ack cycle.
- Strobe handling:
  - Every strobe latches {word, byte-select} as pending, even when the block is busy.
  - A new strobe overwrites any unserved pending request (latest wins).
- Serving a pending request, evaluated in IDLE, or on the same cycle for a strobe arriving in IDLE:
  - Hit on current tag: spi_read_ready pulses on the next cycle (latency 1).
  - Hit on next-buffer tag: next becomes current; ready pulses on the next cycle; if PREFETCH, go to PREF for word+1.
  - Miss: go to DEMAND. ready pulses on the cycle after sd_ack, with the byte taken from the captured word. The captured word becomes current; the next buffer is invalidated. If PREFETCH, go to PREF; otherwise go to IDLE.
- Strobe during PREF or WRITE:
  - The SDRAM access is never aborted; it completes first.
  - PREF completion: next buffer becomes valid, then the pending request is evaluated immediately (it may hit the new next buffer).
- Word+1 arithmetic is modulo 2^ADDR_WIDTH: word address all-ones prefetches word 0.
- Host write port:
  - host_wr_ready = 1 only in IDLE with no pending SPI request and spi_critical=0.
  - Accepted strobe: go to WRITE with sd_we=1; return to IDLE on the cycle after sd_ack.
  - Any buffer whose tag equals host_wr_addr is invalidated when the strobe is accepted.
- Simultaneous SPI strobe and accepted host strobe in the same cycle: the SPI request wins and the host strobe is ignored (the host must retry). Therefore host_wr_ready is also gated combinationally by !spi_read_strobe.
- Reset mid-access: sd_enable drops immediately. sdram_ctrl is reset by its own reset path. No ready pulse is emitted for the interrupted request.

Test Plan:
- Host writes word 0x000010=0xBEEF, then SPI strobe with addr 0x000020 -> miss. ready 1 cycle after sd_ack, data 0xEF. Strobe with addr 0x000021 -> ready 1 cycle later, data 0xBE, no sd_enable.
- PREFETCH=1: word 0x11 preloaded with 0x1234. Strobe 0x20, wait for prefetch ack, then strobe 0x22 -> ready latency 1, data 0x34. A new PREF for word 0x12 starts.
- Strobe issued during PREF -> PREF completes with one sd_enable assertion, then the request is served with correct data. Two strobes during PREF -> only the second gets a ready pulse.
- Wrap: read word 0xFFFFFF (addr 0x1FFFFFE) -> PREF issues sd_addr=0x000000.
- spi_critical=1 -> sd_refresh_inhibit=1 one cycle later; host_wr_ready=0 while critical. Host and SPI strobes in the same cycle -> sd_we stays 0 and the SPI read proceeds.
- Host write to the word held in the current buffer, then strobe for that word -> miss; SDRAM is re-read and returns the new value.
